// File: rtl/cu_pkg.sv
// Shared constants, FSM state type and vector arithmetic for interrupt_controller_n.
package cu_pkg;

  localparam logic REG_IF = 1'b0;
  localparam logic REG_IE = 1'b1;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0040;
  localparam int unsigned DEF_VECTOR_STRIDE = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Vector address wraps modulo 2^16.
  function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                              input int unsigned stride,
                                              input logic [2:0]  idx);
    logic [31:0] full;
    full = 32'(base) + 32'(idx) * stride;
    return full[15:0];
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder over N request lines (N <= 8).
module irq_priority_encoder #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_n.sv
// Parametrised interrupt controller: IF/IE, IME with EI delay, priority dispatch.
// Optional macro HALT_BUG_EN adds the o_Halt_Bug output.
module interrupt_controller_n
  import cu_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int unsigned VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  parameter int unsigned EI_DELAY      = 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic [NUM_IRQ-1:0] i_Irq,
  input  logic               i_Reg_Sel,
  input  logic               i_Reg_Wr,
  input  logic [7:0]         i_Reg_Wdata,
  output logic [7:0]         o_Reg_Rdata,
  input  logic               i_Instr_Boundary,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Halt,
  input  logic               i_Int_Ack,
  output logic               o_Int_Req,
  output logic [15:0]        o_Vector,
  output logic               o_Wake,
`ifdef HALT_BUG_EN
  output logic               o_Halt_Bug,
`endif
  output logic               o_IME
);

  logic [NUM_IRQ-1:0] if_q, irq_q, rise, pend, if_nxt, ack_mask;
  logic [7:0]         ie_q, if_rd;
  logic               ime_q;
  logic [1:0]         ei_cnt;
  logic [2:0]         idx_q, enc_idx;
  logic [15:0]        vec_q;
  logic               enc_valid, dispatch, ack_fire;
  state_t             state_q, state_nxt;

  irq_priority_encoder #(.N(NUM_IRQ)) u_enc (
    .req   (pend),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_comb begin
    state_nxt = state_q;
    dispatch  = 1'b0;
    ack_fire  = 1'b0;
    case (state_q)
      IDLE: if (i_Instr_Boundary && ime_q && enc_valid) begin
        dispatch  = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (i_Int_Ack) begin
        ack_fire  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hardware edges are OR-ed in last so they win over software and ack clears.
  always_comb begin
    rise     = i_Irq & ~irq_q;
    pend     = if_q & ie_q[NUM_IRQ-1:0];
    ack_mask = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (idx_q == 3'(i)) ack_mask[i] = 1'b1;
    end
    if_nxt = if_q;
    if (i_Reg_Wr && i_Reg_Sel == REG_IF) if_nxt = i_Reg_Wdata[NUM_IRQ-1:0];
    if (ack_fire) if_nxt = if_nxt & ~ack_mask;
    if_nxt = if_nxt | rise;
  end

  always_comb begin
    if_rd              = '1;
    if_rd[NUM_IRQ-1:0] = if_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= IDLE;
    else if (i_Enable) state_q <= state_nxt;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      if_q   <= '0;
      irq_q  <= '0;
      ie_q   <= '0;
      ime_q  <= 1'b0;
      ei_cnt <= '0;
      idx_q  <= '0;
      vec_q  <= '0;
    end else if (i_Enable) begin
      irq_q <= i_Irq;
      if_q  <= if_nxt;
      if (i_Reg_Wr && i_Reg_Sel == REG_IE) ie_q <= i_Reg_Wdata;
      if (i_DI || ack_fire) begin
        ime_q  <= 1'b0;
        ei_cnt <= '0;
      end else begin
        if (i_EI) begin
          if (EI_DELAY == 0) ime_q <= 1'b1;
          else ei_cnt <= 2'(EI_DELAY);
        end else if (i_Instr_Boundary && ei_cnt != '0) begin
          ei_cnt <= ei_cnt - 2'd1;
          if (ei_cnt == 2'd1) ime_q <= 1'b1;
        end
        if (i_RETI) ime_q <= 1'b1;
      end
      if (dispatch) begin
        idx_q <= enc_idx;
        vec_q <= calc_vector(VECTOR_BASE, VECTOR_STRIDE, enc_idx);
      end
    end
  end

`ifdef HALT_BUG_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) o_Halt_Bug <= 1'b0;
    else if (i_Enable) o_Halt_Bug <= i_Halt && !ime_q && (|pend);
  end
`else
  logic unused_halt;
  assign unused_halt = i_Halt;
`endif

  assign o_Reg_Rdata = (i_Reg_Sel == REG_IE) ? ie_q : if_rd;
  assign o_Int_Req   = (state_q == REQ);
  assign o_Vector    = vec_q;
  assign o_Wake      = |pend;
  assign o_IME       = ime_q;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Bench for interrupt_controller_n: register table, directed corner cases, random vs model.
module tb_interrupt_controller_n;

  localparam int NUM_IRQ = 5;
  localparam int EI_DEL  = 1;
  localparam int BASE    = 'h0040;
  localparam int STRIDE  = 8;
  localparam int MASK    = (1 << NUM_IRQ) - 1;

  logic clk, rst, en;
  logic [NUM_IRQ-1:0] irq;
  logic reg_sel, reg_wr;
  logic [7:0] wdata, rdata;
  logic boundary, ei, di, reti, halt, ack;
  logic int_req, wake, ime;
  logic [15:0] vec;
  logic hb;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_if, m_ie, m_ime, m_cnt, m_req, m_idx, m_vec, m_prev, m_hb;

  interrupt_controller_n #(
    .NUM_IRQ(NUM_IRQ), .VECTOR_BASE(16'h0040), .VECTOR_STRIDE(8), .EI_DELAY(EI_DEL)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Irq(irq),
    .i_Reg_Sel(reg_sel), .i_Reg_Wr(reg_wr), .i_Reg_Wdata(wdata), .o_Reg_Rdata(rdata),
    .i_Instr_Boundary(boundary), .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Halt(halt),
    .i_Int_Ack(ack), .o_Int_Req(int_req), .o_Vector(vec), .o_Wake(wake),
`ifdef HALT_BUG_EN
    .o_Halt_Bug(hb),
`endif
    .o_IME(ime)
  );

`ifndef HALT_BUG_EN
  assign hb = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Next state computed from the previous model state and current inputs.
  task automatic model_step();
    int edges, nif, nie, nime, ncnt, nreq, nidx, nvec, nhb, pend;
    if (rst) begin
      m_if = 0; m_ie = 0; m_ime = 0; m_cnt = 0; m_req = 0; m_idx = 0;
      m_vec = 0; m_prev = 0; m_hb = 0;
      return;
    end
    if (!en) return;
    pend  = m_if & m_ie & MASK;
    edges = int'(irq) & ~m_prev & MASK;
    nif = m_if;
    if (reg_wr && !reg_sel) nif = int'(wdata) & MASK;
    if (m_req && ack) nif = nif & ~(1 << m_idx);
    nif = nif | edges;
    nie = (reg_wr && reg_sel) ? int'(wdata) : m_ie;
    nime = m_ime; ncnt = m_cnt;
    if (di || (m_req && ack)) begin
      nime = 0; ncnt = 0;
    end else begin
      if (ei) begin
        if (EI_DEL == 0) nime = 1; else ncnt = EI_DEL;
      end else if (boundary && m_cnt > 0) begin
        ncnt = m_cnt - 1;
        if (ncnt == 0) nime = 1;
      end
      if (reti) nime = 1;
    end
    nreq = m_req; nidx = m_idx; nvec = m_vec;
    if (!m_req && boundary && m_ime != 0 && pend != 0) begin
      nreq = 1; nidx = lowest(pend); nvec = (BASE + nidx * STRIDE) % 65536;
    end else if (m_req && ack) begin
      nreq = 0;
    end
    nhb = (halt && m_ime == 0 && pend != 0) ? 1 : 0;
    m_if = nif; m_ie = nie; m_ime = nime; m_cnt = ncnt; m_req = nreq;
    m_idx = nidx; m_vec = nvec; m_prev = int'(irq); m_hb = nhb;
  endtask

  task automatic cycle();
    int exp_rd;
    @(posedge clk);
    model_step();
    #1;
    exp_rd = reg_sel ? m_ie : ((~MASK & 'hFF) | m_if);
    check("m_int_req", 32'(int_req), m_req);
    check("m_vector", 32'(vec), m_vec);
    check("m_ime", 32'(ime), m_ime);
    check("m_wake", 32'(wake), ((m_if & m_ie & MASK) != 0) ? 1 : 0);
    check("m_rdata", 32'(rdata), exp_rd);
`ifdef HALT_BUG_EN
    check("m_halt_bug", 32'(hb), m_hb);
`endif
  endtask

  task automatic chk_reg(input string name, input logic sel, input logic [7:0] exp);
    reg_sel = sel;
    #1;
    check(name, 32'(rdata), 32'(exp));
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] d);
    reg_wr = 1'b1; reg_sel = sel; wdata = d;
    cycle();
    reg_wr = 1'b0;
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } reg_vec_t;

  reg_vec_t tbl[6];

  initial begin
    rst = 1'b1; en = 1'b1; irq = '0; reg_sel = 1'b0; reg_wr = 1'b0; wdata = '0;
    boundary = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; halt = 1'b0; ack = 1'b0;
    m_if = 0; m_ie = 0; m_ime = 0; m_cnt = 0; m_req = 0; m_idx = 0;
    m_vec = 0; m_prev = 0; m_hb = 0;

    tbl[0] = '{1'b0, 8'hFF, 8'hFF};
    tbl[1] = '{1'b0, 8'h15, 8'hF5};
    tbl[2] = '{1'b0, 8'h0A, 8'hEA};
    tbl[3] = '{1'b1, 8'hA5, 8'hA5};
    tbl[4] = '{1'b1, 8'h00, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 8'hE0};

    // Reset state
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk_reg("rst_if", 1'b0, 8'hE0);
    chk_reg("rst_ie", 1'b1, 8'h00);
    check("rst_req", 32'(int_req), 0);
    check("rst_vec", 32'(vec), 0);
    check("rst_ime", 32'(ime), 0);

    // Register write/readback table
    foreach (tbl[i]) begin
      write_reg(tbl[i].sel, tbl[i].data);
      chk_reg($sformatf("tbl_%0d", i), tbl[i].sel, tbl[i].exp_rd);
    end

    // Two simultaneous edges, lowest index wins
    write_reg(1'b1, 8'h1F);
    reti = 1'b1; cycle(); reti = 1'b0;
    check("reti_ime", 32'(ime), 1);
    irq = 5'b10100; cycle();
    chk_reg("two_edge_if", 1'b0, 8'hF4);
    irq = '0; boundary = 1'b1; cycle(); boundary = 1'b0;
    check("disp_req", 32'(int_req), 1);
    check("disp_vec", 32'(vec), 'h0050);
    ack = 1'b1; cycle(); ack = 1'b0;
    chk_reg("ack_if", 1'b0, 8'hF0);
    check("ack_ime", 32'(ime), 0);
    check("ack_req", 32'(int_req), 0);

    // EI delay: second boundary dispatches
    irq = 5'b00001; cycle(); irq = '0;
    ei = 1'b1; cycle(); ei = 1'b0;
    boundary = 1'b1; cycle(); boundary = 1'b0;
    check("ei_b1_req", 32'(int_req), 0);
    check("ei_b1_ime", 32'(ime), 1);
    cycle();
    boundary = 1'b1; cycle(); boundary = 1'b0;
    check("ei_b2_req", 32'(int_req), 1);
    check("ei_b2_vec", 32'(vec), 'h0040);
    ack = 1'b1; cycle(); ack = 1'b0;
    write_reg(1'b0, 8'h00);

    // Held level does not re-set IF; edge beats same-cycle clear
    reti = 1'b1; cycle(); reti = 1'b0;
    irq = 5'b00010; cycle();
    boundary = 1'b1; cycle(); boundary = 1'b0;
    check("lvl_vec", 32'(vec), 'h0048);
    ack = 1'b1; cycle(); ack = 1'b0;
    repeat (8) cycle();
    chk_reg("lvl_if", 1'b0, 8'hE0);
    irq = '0; cycle();
    irq = 5'b00010; write_reg(1'b0, 8'h00);
    chk_reg("edge_vs_clr", 1'b0, 8'hE2);

    // Wake without IME
    irq = '0; write_reg(1'b0, 8'h00);
    irq = 5'b01000; cycle();
    check("wake", 32'(wake), 1);
    boundary = 1'b1; cycle(); boundary = 1'b0;
    check("wake_noreq", 32'(int_req), 0);
`ifdef HALT_BUG_EN
    halt = 1'b1; cycle(); halt = 1'b0;
    check("hb_pulse", 32'(hb), 1);
    cycle();
    check("hb_drop", 32'(hb), 0);
`endif

    // Reset while requesting
    irq = '0;
    reti = 1'b1; cycle(); reti = 1'b0;
    boundary = 1'b1; cycle(); boundary = 1'b0;
    check("pre_rst_req", 32'(int_req), 1);
    check("pre_rst_vec", 32'(vec), 'h0058);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("midrst_req", 32'(int_req), 0);
    check("midrst_ime", 32'(ime), 0);
    chk_reg("midrst_if", 1'b0, 8'hE0);

    // Clock enable freezes state
    write_reg(1'b1, 8'h1F);
    en = 1'b0; irq = 5'b00001; cycle();
    chk_reg("en0_if", 1'b0, 8'hE0);
    cycle();
    chk_reg("en0_if2", 1'b0, 8'hE0);
    en = 1'b1; cycle();
    chk_reg("en1_if", 1'b0, 8'hE1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 9) != 0);
      irq      = NUM_IRQ'($urandom_range(0, MASK));
      boundary = ($urandom_range(0, 2) == 0);
      ei       = ($urandom_range(0, 15) == 0);
      di       = ($urandom_range(0, 19) == 0);
      reti     = ($urandom_range(0, 15) == 0);
      halt     = ($urandom_range(0, 7) == 0);
      ack      = (m_req != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      reg_wr   = ($urandom_range(0, 9) == 0);
      reg_sel  = 1'($urandom_range(0, 1));
      wdata    = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller_n.md
Name: interrupt_controller_n

Overview:
- Parametrised successor to the CPU's fixed 5-source interrupt logic; owns IF/IE registers, IME with configurable EI delay, priority selection, and the dispatch handshake with the ControlUnit.
- Sits beside the ControlUnit. The ControlUnit supplies instruction-boundary, EI/DI/RETI and HALT strobes. It consumes o_Int_Req/o_Vector to run the interrupt microcode, and o_Wake to leave HALT.

Parameters:
- NUM_IRQ, 5, number of interrupt sources (1..8); index 0 has highest priority.
- VECTOR_BASE, 16'h0040, vector of source 0.
- VECTOR_STRIDE, 8, byte spacing between consecutive vectors.
- EI_DELAY, 1, instruction boundaries after EI before IME is set (0..3).

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous reset, active-high
- i_Enable  in  1  clock enable; when low, all state is frozen and inputs are ignored
- i_Irq  in  NUM_IRQ  source request lines; a rising edge sets the matching IF bit
- i_Reg_Sel  in  1  0=IF, 1=IE
- i_Reg_Wr  in  1  register write strobe
- i_Reg_Wdata  in  8  write data
- o_Reg_Rdata  out  8  read data (combinational)
- i_Instr_Boundary  in  1  high for one cycle on the opcode-fetch step
- i_EI  in  1  EI executed
- i_DI  in  1  DI executed
- i_RETI  in  1  RETI executed
- i_Halt  in  1  HALT executed
- i_Int_Ack  in  1  ControlUnit has started the dispatch microcode
- o_Int_Req  out  1  dispatch request
- o_Vector  out  16  target address; stable while o_Int_Req is high
- o_Wake  out  1  |(IF & IE[NUM_IRQ-1:0]), independent of IME
- o_IME  out  1  current master enable

Behaviour:
- Reset (i_Rst=1 on an enabled or disabled edge):
  - IF=0, IE=0, IME=0, EI counter=0, edge regs=0, state IDLE.
  - o_Int_Req=0, o_Vector=0, o_IME=0; o_Wake=0 follows.
  - Reset mid-REQ drops o_Int_Req on the next edge.
- Edge detect: i_Irq is registered each enabled cycle. A 0->1 transition sets IF[k] on the following edge (1-cycle latency). A level held high does not re-set IF.
- Register reads:
  - IF reads {1 in bits 7:NUM_IRQ, IF}.
  - IE reads all 8 stored bits.
- Register writes:
  - IF write stores only the low NUM_IRQ bits.
  - IE write stores all 8 bits; only the low NUM_IRQ bits gate interrupts.
- Set priority: a same-cycle hardware edge on bit k beats both a software clear of IF[k] and an ack clear of IF[k].
- IME:
  - i_EI loads the counter with EI_DELAY. Each i_Instr_Boundary with counter>0 decrements it; the step that reaches 0 sets IME on that edge.
  - EI_DELAY=0: IME is set on the edge after i_EI.
  - i_RETI sets IME on the next edge.
  - i_DI clears IME and the counter.
  - DI beats EI and RETI in the same cycle; ack beats EI and RETI.
- State IDLE: on i_Instr_Boundary & IME & |(IF&IE):
  - latch idx = lowest set bit of (IF & IE);
  - o_Vector <= VECTOR_BASE + idx*VECTOR_STRIDE, 16-bit, wraps mod 2^16;
  - go to REQ.
  - IME is sampled as registered, so with EI_DELAY=1 the first possible dispatch is at the second boundary after EI.
- State REQ:
  - o_Int_Req=1; idx and o_Vector are held.
  - On i_Int_Ack: clear IF[idx], clear IME and the EI counter, go to IDLE; o_Int_Req falls on the same edge.
  - If IE[idx] or IF[idx] is cleared by software while in REQ, the request is still completed with the latched vector.
- Boundaries while in REQ are ignored; no re-arbitration.
- i_Halt is used only by the optional feature; wake-from-HALT is o_Wake.

Optional Feature:
- Macro HALT_BUG_EN.
- Defined:
  - adds output o_Halt_Bug (1 bit, reset 0);
  - pulses for one cycle after i_Halt when IME=0 and o_Wake=1 in that cycle;
  - the ControlUnit then suppresses the next PC increment.
- Undefined: port absent; i_Halt is unused.

Decomposition:
- Package cu_pkg:
  - REG_IF/REG_IE select constants;
  - state enum {IDLE, REQ};
  - default VECTOR_BASE/VECTOR_STRIDE constants.
- One sub-module, irq_priority_encoder: NUM_IRQ-wide, lowest-index-first encoder producing a valid flag and index. It generalises the existing fixed-width address encoder.

Test Plan:
- Reset, then read IF with NUM_IRQ=5 -> 8'hE0; IE -> 8'h00; o_Int_Req=0.
- IE=8'h1F, IME set via RETI, edges on i_Irq[2] and i_Irq[4] in the same cycle, then a boundary -> o_Int_Req=1, o_Vector=16'h0050; ack -> IF=8'hF0, IME=0, o_Int_Req=0.
- EI (EI_DELAY=1) with IF[0]&IE[0] pending -> no request at boundary 1; request at boundary 2 with o_Vector=16'h0040.
- i_Irq[1] held high for 10 cycles, ack, keep it high -> IF[1] stays 0 (edge only); same-cycle IF-clear write and new edge -> IF[1]=1.
- IME=0, IE[3]=1, edge on i_Irq[3] -> o_Wake=1, o_Int_Req stays 0; with HALT_BUG_EN defined, i_Halt -> o_Halt_Bug pulses once.
- Assert i_Rst during REQ -> o_Int_Req=0, IF=0, IME=0 next cycle.
- i_Enable=0 during an i_Irq edge -> no state change.
